// File: rtl/sap_pkg.sv
// Shared SAP definitions: word/address widths and the program-button FSM states.
package sap_pkg;

    localparam int SAP_DATA_WIDTH = 8;
    localparam int SAP_ADDR_WIDTH = 4;

    // Program-button controller states with fixed encodings.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_WRITE    = 2'd2,
        ST_RELEASE  = 2'd3
    } btn_state_t;

endpackage

// File: rtl/prog_button_ctrl.sv
// Program-mode write button: 2-flop synchronizer, debounce counter and a
// one-shot FSM that yields exactly one write strobe per physical press.
module prog_button_ctrl
    import sap_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic clear,
    input  logic btn_raw,
    input  logic prog_mode,
    output logic write_ack
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             btn_s;
    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            sync_meta <= 1'b0;
            btn_s     <= 1'b0;
        end else begin
            sync_meta <= btn_raw;
            btn_s     <= sync_meta;
        end
    end

    // State and stability-counter registers.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every flop
            // samples pre-edge values regardless of block evaluation order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, counter update and the write strobe.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d   = state_q;
        cnt_d     = cnt_q;
        write_ack = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (btn_s) begin
                    state_d = ST_DEBOUNCE;
                    cnt_d   = '0;
                end
            end
            ST_DEBOUNCE: begin
                if (!btn_s) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_WRITE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WRITE: begin
                write_ack = 1'b1;
                state_d   = ST_RELEASE;
                cnt_d     = '0;
            end
            ST_RELEASE: begin
                if (btn_s) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        // Leaving program mode aborts any sequence and suppresses the strobe.
        if (!prog_mode) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            write_ack = 1'b0;
        end
    end

endmodule

// File: rtl/sap_ram.sv
// SAP 16x8 program/data RAM: run-mode bus writes, program-mode DIP-switch
// writes through the debounced button, and combinational read paths.
module sap_ram
    import sap_pkg::*;
#(
    parameter int DATA_WIDTH      = SAP_DATA_WIDTH,
    parameter int ADDR_WIDTH      = SAP_ADDR_WIDTH,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] bus_in,
    input  logic                  ram_in,
    input  logic                  ram_out,
    output logic [DATA_WIDTH-1:0] bus_out,
    output logic                  bus_oe,
    input  logic                  prog_mode,
    input  logic [DATA_WIDTH-1:0] prog_data,
    input  logic                  prog_write_btn,
    output logic                  write_ack,
    output logic [DATA_WIDTH-1:0] data_view
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    prog_button_ctrl #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk      (clk),
        .clear    (clear),
        .btn_raw  (prog_write_btn),
        .prog_mode(prog_mode),
        .write_ack(write_ack)
    );

    // Write port: program strobe in program mode, RI in run mode.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            // NOTE: this array is cleared on reset because the SAP relies on a
            // zeroed memory; that forces flops rather than a RAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (prog_mode) begin
            if (write_ack) begin
                mem[address] <= prog_data;
            end
        end else if (ram_in) begin
            mem[address] <= bus_in;
        end
    end

    // Asynchronous read paths for the bus driver and the LED display.
    always_comb begin
        data_view = mem[address];
        bus_out   = ram_out ? mem[address] : '0;
        bus_oe    = ram_out;
    end

endmodule

// File: tb/tb_sap_ram.sv
// Self-checking bench for sap_ram: directed scenarios plus randomized run-mode
// traffic and program-mode presses against an array model of the memory.
module tb_sap_ram;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int DEB   = 4;

    logic          clk = 1'b0;
    logic          clear;
    logic [AW-1:0] address;
    logic [DW-1:0] bus_in;
    logic          ram_in;
    logic          ram_out;
    logic [DW-1:0] bus_out;
    logic          bus_oe;
    logic          prog_mode;
    logic [DW-1:0] prog_data;
    logic          prog_write_btn;
    logic          write_ack;
    logic [DW-1:0] data_view;

    int n_checks = 0;
    int n_pass   = 0;
    int edge_n   = 0;
    int ack_total = 0;
    int last_ack_edge = -1;

    logic [DW-1:0] model [DEPTH];

    sap_ram #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk), .clear(clear), .address(address), .bus_in(bus_in),
        .ram_in(ram_in), .ram_out(ram_out), .bus_out(bus_out), .bus_oe(bus_oe),
        .prog_mode(prog_mode), .prog_data(prog_data),
        .prog_write_btn(prog_write_btn), .write_ack(write_ack),
        .data_view(data_view)
    );

    always #5 clk = ~clk;

    // Number the rising edges.
    always @(posedge clk) edge_n <= edge_n + 1;

    // Record strobes mid-cycle; the commit happens at the next rising edge.
    always @(negedge clk) begin
        if (write_ack === 1'b1) begin
            ack_total     <= ack_total + 1;
            last_ack_edge <= edge_n + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        address = a;
        bus_in  = d;
        ram_in  = 1'b1;
        tick();
        ram_in  = 1'b0;
        model[a] = d;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            address = AW'(i);
            #1;
            check(tag, 32'(data_view), 32'(model[i]));
        end
    endtask

    // Clean press: button held `hold` cycles, then released long enough to re-arm.
    task automatic press(input logic [AW-1:0] a, input logic [DW-1:0] d, input int hold);
        int k;
        int ack0;
        address   = a;
        prog_data = d;
        prog_write_btn = 1'b1;
        k    = edge_n;
        ack0 = ack_total;
        repeat (hold) tick();
        prog_write_btn = 1'b0;
        repeat (DEB + 4) tick();
        check("press_ack_count", 32'(ack_total), 32'(ack0 + 1));
        check("press_commit_edge", 32'(last_ack_edge), 32'(k + DEB + 4));
        model[a] = d;
        address = a;
        #1;
        check("press_data", 32'(data_view), 32'(d));
    endtask

    initial begin
        int k;
        int ack0;
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;
        logic ri, ro, pm;

        clear = 1'b1; address = '0; bus_in = '0; ram_in = 1'b0; ram_out = 1'b0;
        prog_mode = 1'b0; prog_data = '0; prog_write_btn = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        repeat (3) tick();
        clear = 1'b0;
        tick();

        // Reset: preload, pulse clear mid-cycle, everything reads back zero.
        run_write(4'd1, 8'h5A);
        run_write(4'd7, 8'hC3);
        run_write(4'd15, 8'h99);
        address = 4'd7;
        #1;
        check("preload", 32'(data_view), 32'h0000_00C3);
        #1 clear = 1'b1;
        #1 clear = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        check_all("reset_mem");
        check("reset_ack", 32'(write_ack), 32'd0);
        check("reset_bus_out", 32'(bus_out), 32'd0);
        check("reset_bus_oe", 32'(bus_oe), 32'd0);
        tick();

        // Run write then read onto the bus.
        run_write(4'd5, 8'hA7);
        ram_out = 1'b1;
        #1;
        check("run_bus_out", 32'(bus_out), 32'h0000_00A7);
        check("run_bus_oe", 32'(bus_oe), 32'd1);
        address = 4'd6;
        #1;
        check("run_bus_out_other", 32'(bus_out), 32'd0);
        ram_out = 1'b0;
        #1;
        check("bus_out_gated", 32'(bus_out), 32'd0);

        // Simultaneous RI/RO: old word before the edge, new word after.
        run_write(4'd9, 8'h11);
        address = 4'd9; bus_in = 8'h22; ram_in = 1'b1; ram_out = 1'b1;
        #1;
        check("rio_before", 32'(bus_out), 32'h0000_0011);
        tick();
        check("rio_after", 32'(bus_out), 32'h0000_0022);
        model[9] = 8'h22;
        ram_in = 1'b0; ram_out = 1'b0;

        // Program write with a bouncing button.
        prog_mode = 1'b1; address = 4'd3; prog_data = 8'h3C;
        ack0 = ack_total;
        for (int i = 0; i < 6; i++) begin
            prog_write_btn = (i % 2 == 0);
            tick();
        end
        prog_write_btn = 1'b1;
        k = edge_n;
        repeat (20) tick();
        prog_write_btn = 1'b0;
        repeat (DEB + 4) tick();
        check("bounce_ack_count", 32'(ack_total), 32'(ack0 + 1));
        check("bounce_commit_edge", 32'(last_ack_edge), 32'(k + 8));
        model[3] = 8'h3C;
        #1;
        check("bounce_data", 32'(data_view), 32'h0000_003C);

        // Short glitch shorter than the debounce window.
        ack0 = ack_total;
        address = 4'd8; prog_data = 8'hEE;
        prog_write_btn = 1'b1;
        repeat (3) tick();
        prog_write_btn = 1'b0;
        repeat (10) tick();
        check("glitch_no_ack", 32'(ack_total), 32'(ack0));
        check_all("glitch_mem");

        // Interlock: RI ignored in program mode.
        address = 4'd2; bus_in = 8'hFF; ram_in = 1'b1;
        tick();
        ram_in = 1'b0;
        #1;
        check("interlock_ri", 32'(data_view), 32'(model[2]));

        // Dropping program mode during debounce cancels the write.
        ack0 = ack_total;
        address = 4'd4; prog_data = 8'h5A;
        prog_write_btn = 1'b1;
        repeat (5) tick();
        prog_mode = 1'b0;
        repeat (10) tick();
        prog_write_btn = 1'b0;
        repeat (DEB + 4) tick();
        prog_mode = 1'b1;
        repeat (4) tick();
        check("mode_drop_no_ack", 32'(ack_total), 32'(ack0));
        address = 4'd4;
        #1;
        check("mode_drop_mem", 32'(data_view), 32'(model[4]));

        // Clear mid-sequence: no partial write, memory zeroed.
        ack0 = ack_total;
        address = 4'd10; prog_data = 8'h77;
        prog_write_btn = 1'b1;
        repeat (5) tick();
        #1 clear = 1'b1;
        prog_write_btn = 1'b0;
        #1;
        check("clear_mid_ack", 32'(write_ack), 32'd0);
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        tick();
        clear = 1'b0;
        repeat (10) tick();
        check("clear_mid_no_ack", 32'(ack_total), 32'(ack0));
        check_all("clear_mid_mem");

        // Randomized program presses with varying hold times.
        for (int n = 0; n < 6; n++) begin
            press(AW'($urandom_range(0, DEPTH - 1)), DW'($urandom), int'($urandom_range(10, 20)));
        end

        // Randomized run-mode traffic, occasionally in program mode (no writes).
        for (int n = 0; n < 300; n++) begin
            ra = AW'($urandom_range(0, DEPTH - 1));
            rd = DW'($urandom);
            ri = 1'($urandom_range(0, 1));
            ro = 1'($urandom_range(0, 1));
            pm = ($urandom_range(0, 7) == 0);
            address = ra; bus_in = rd; ram_in = ri; ram_out = ro; prog_mode = pm;
            #1;
            check("rand_view", 32'(data_view), 32'(model[ra]));
            check("rand_bus", 32'(bus_out), ro ? 32'(model[ra]) : 32'd0);
            check("rand_oe", 32'(bus_oe), 32'(ro));
            tick();
            if (ri && !pm) model[ra] = rd;
        end
        ram_in = 1'b0; ram_out = 1'b0; prog_mode = 1'b0;
        check_all("final_mem");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
